// File: rtl/rx_frame_ctrl.sv
// Receive-side sequencer for the parity decoder.
// Issues coded words to the decoder, tracks the decoder latency with a tag
// pipe, parses the decoded byte stream into SOF/length/payload/checksum
// frames, streams payload downstream and reports per-frame status.
module rx_frame_ctrl #(
  parameter int DATA_WIDTH  = 8,
  parameter int DEC_LATENCY = 1,
  parameter int SOF         = 'hA5,
  parameter int MAX_LEN     = 64,
  parameter int TIMEOUT     = 32
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH:0]   s_data,
  output logic [DATA_WIDTH:0]   dec_in,
  input  logic [DATA_WIDTH-1:0] dec_out_byte,
  input  logic                  dec_err,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  frame_ok,
  output logic                  frame_err,
  output logic [1:0]            err_code,
  output logic [15:0]           err_cnt
);

  typedef enum logic [1:0] {IDLE, LEN, PAYLOAD, CHECK} state_t;

  localparam logic [1:0] ERR_PARITY   = 2'd0;
  localparam logic [1:0] ERR_LENGTH   = 2'd1;
  localparam logic [1:0] ERR_CHECKSUM = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

  localparam logic [DATA_WIDTH-1:0] SOF_BYTE = DATA_WIDTH'(SOF);
  localparam logic [DATA_WIDTH-1:0] MAX_BYTE = DATA_WIDTH'(MAX_LEN);
  localparam int                    TW       = $clog2(TIMEOUT);
  localparam logic [TW-1:0]         TMO_LAST = TW'(TIMEOUT - 1);

  state_t                state;
  logic [DEC_LATENCY:0]  tag;
  logic                  accept;
  logic                  sample;
  logic [DATA_WIDTH-1:0] remaining;
  logic [DATA_WIDTH-1:0] csum;
  logic [TW-1:0]         tmo_cnt;
  logic                  abort;
  logic [1:0]            abort_code;
  logic [1:0]            err_inc;
  logic [16:0]           cnt_sum;

  assign accept = s_valid & s_ready;
  // Bit 0 marks a freshly issued dec_in; the following DEC_LATENCY bits follow
  // the word through the decoder, so the tail lines up with its result.
  assign sample = tag[DEC_LATENCY];

  // Issue path: always ready after reset, capture accepted words, track tags.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      s_ready <= 1'b0;
      dec_in  <= '0;
      tag     <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      s_ready <= 1'b1;
      if (accept) dec_in <= s_data;
      tag <= {tag[DEC_LATENCY-1:0], accept};
    end
  end

  // Per-cycle decision: does this cycle abort the frame, and by how much the
  // error counter moves.
  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latch).
    abort      = 1'b0;
    abort_code = ERR_PARITY;
    err_inc    = 2'd0;
    if (sample) begin
      case (state)
        IDLE:    if (dec_err) err_inc = 2'd1;
        LEN: begin
          if (dec_err) begin
            abort = 1'b1;
          end else if (dec_out_byte == '0 || dec_out_byte > MAX_BYTE) begin
            abort      = 1'b1;
            abort_code = ERR_LENGTH;
          end
        end
        PAYLOAD: if (dec_err) abort = 1'b1;
        CHECK: begin
          if (dec_err) begin
            abort = 1'b1;
          end else if (dec_out_byte != csum) begin
            abort      = 1'b1;
            abort_code = ERR_CHECKSUM;
          end
        end
        default: ;
      endcase
    end else if (state != IDLE && tmo_cnt == TMO_LAST) begin
      abort      = 1'b1;
      abort_code = ERR_TIMEOUT;
    end
    if (abort) err_inc = (abort_code == ERR_PARITY) ? 2'd2 : 2'd1;
  end

  assign cnt_sum = {1'b0, err_cnt} + 17'(err_inc);

  // Frame FSM with registered outputs, timeout counter and error counter.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state     <= IDLE;
      remaining <= '0;
      csum      <= '0;
      tmo_cnt   <= '0;
      m_valid   <= 1'b0;
      m_data    <= '0;
      m_last    <= 1'b0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= ERR_PARITY;
      err_cnt   <= '0;
    end else begin
      m_valid   <= 1'b0;
      m_last    <= 1'b0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      if (err_inc != 2'd0) err_cnt <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];

      if (abort) begin
        state     <= IDLE;
        frame_err <= 1'b1;
        err_code  <= abort_code;
        tmo_cnt   <= '0;
      end else if (sample) begin
        tmo_cnt <= '0;
        case (state)
          IDLE: begin
            if (!dec_err && dec_out_byte == SOF_BYTE) begin
              state <= LEN;
              csum  <= '0;
            end
          end
          LEN: begin
            remaining <= dec_out_byte;
            state     <= PAYLOAD;
          end
          PAYLOAD: begin
            m_valid   <= 1'b1;
            m_data    <= dec_out_byte;
            csum      <= csum ^ dec_out_byte;
            remaining <= remaining - DATA_WIDTH'(1);
            if (remaining == DATA_WIDTH'(1)) begin
              m_last <= 1'b1;
              state  <= CHECK;
            end
          end
          CHECK: begin
            frame_ok <= 1'b1;
            state    <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end else if (state != IDLE) begin
        tmo_cnt <= tmo_cnt + TW'(1);
      end
    end
  end

endmodule

// File: doc/rx_frame_ctrl.md
Name: rx_frame_ctrl

Overview:
- Receive-side sequencer for the parity decoder in the transceiver.
- Accepts 9-bit coded words from the line side and issues them to the decoder.
- Tracks the decoder's fixed pipeline latency, parses the decoded byte stream into frames (SOF, length, payload, XOR checksum), and streams payload bytes downstream.
- Reports per-frame pass/fail, an error code, and a saturating error count.

Parameters:
- DATA_WIDTH, 8, decoded byte width; coded word is DATA_WIDTH+1 bits.
- DEC_LATENCY, 1, cycles from dec_in update to dec_out_byte/dec_err valid (1..4).
- SOF, 8'hA5, start-of-frame byte.
- MAX_LEN, 64, maximum payload length in bytes (1..255).
- TIMEOUT, 32, idle cycles allowed inside a frame before abort (>=2).

Ports:
- clk  in  1  clock, rising edge.
- arst  in  1  asynchronous reset, active-low.
- s_valid  in  1  coded word valid.
- s_ready  out  1  controller accepts word.
- s_data  in  DATA_WIDTH+1  coded word.
- dec_in  out  DATA_WIDTH+1  word driven to decoder in.
- dec_out_byte  in  DATA_WIDTH  decoder out_byte.
- dec_err  in  1  decoder err.
- m_valid  out  1  payload byte strobe.
- m_data  out  DATA_WIDTH  payload byte.
- m_last  out  1  last payload byte of frame.
- frame_ok  out  1  one-cycle pulse, frame passed.
- frame_err  out  1  one-cycle pulse, frame aborted.
- err_code  out  2  0 parity, 1 bad length, 2 checksum, 3 timeout; valid with frame_err, held until next frame_err.
- err_cnt  out  16  saturating count of dec_err words plus aborted frames.

Behaviour:
- Reset (arst low, asynchronous):
  - All outputs 0; s_ready 0.
  - FSM to IDLE; tag pipe, timeout counter, length and checksum registers cleared.
- First rising clk edge after release: s_ready 1. s_ready stays 1 thereafter; no upstream backpressure.
- Issue: on accept (s_valid&s_ready) at edge t:
  - dec_in <= s_data at edge t.
  - A 1 enters the DEC_LATENCY-deep tag shift register. Non-accept cycles shift in 0.
  - dec_in holds its value when no word is accepted.
- Sample: when the tag tail is 1, the controller consumes dec_out_byte/dec_err that cycle. Results are registered at edge t+DEC_LATENCY+1.
- Latency: accept to m_valid = DEC_LATENCY+1 cycles. Back-to-back accepts give back-to-back m_valid.
- FSM, applied to each sampled word:
  - IDLE:
    - dec_err: err_cnt++, stay IDLE, no frame_err.
    - Byte==SOF: go to LEN, clear checksum.
    - Any other byte: discard.
  - LEN:
    - dec_err: abort, code 0.
    - Byte==0 or >MAX_LEN: abort, code 1.
    - Otherwise: latch remaining=byte, go to PAYLOAD.
  - PAYLOAD:
    - dec_err: abort, code 0.
    - Otherwise: m_valid=1, m_data=byte, checksum^=byte, remaining--.
    - When remaining was 1: m_last=1, go to CHECK.
  - CHECK:
    - dec_err: abort, code 0.
    - Byte==checksum: frame_ok pulse, go to IDLE.
    - Otherwise: abort, code 2.
  - Abort: frame_err pulse, err_code updated, err_cnt++ (plus 1 more if the cause was dec_err, total +2), FSM to IDLE.
- Payload already streamed is not retracted. Downstream discards the frame on frame_err.
- Timeout:
  - Counter runs in LEN/PAYLOAD/CHECK.
  - Clears on every sampled word and on entry to IDLE.
  - On reaching TIMEOUT with no sampled word that cycle: abort, code 3.
  - A word sampled in the same cycle as the timeout wins; the counter clears.
- Words in flight in the tag pipe when an abort occurs are processed normally from IDLE (SOF hunting). There is no flush.
- frame_ok/frame_err/m_valid/m_last are single-cycle pulses. frame_ok and m_last are never high in the same cycle.
- err_cnt saturates at 16'hFFFF.
- arst asserted mid-frame: immediate return to reset state. No pulse is emitted.

Test Plan:
- Good frame: A5,03,11,22,33,00 (decoder model, DEC_LATENCY=1, back-to-back) -> m_valid 3 consecutive cycles with 11,22,33, m_last on 33; frame_ok 1 cycle after m_last's cycle; err_cnt 0; first m_valid 2 cycles after the accept of 11.
- Parity error: A5,02,44 with dec_err on 44 -> frame_err, err_code 0, err_cnt 2, no m_valid for 44. Following A5,01,7E,7E -> frame_ok.
- Bad length: A5,00 -> frame_err code 1. A5,41 with MAX_LEN=64 -> frame_err code 1. No m_valid in either case.
- Checksum: A5,02,0F,F0,00 -> m_valid 0F,F0, then frame_err code 2. The same frame with check byte FF -> frame_ok.
- Timeout: A5,02,10, then s_valid low for 40 cycles -> frame_err code 3 exactly TIMEOUT cycles after 10 is sampled. A subsequent good frame passes.
- Reset mid-frame: arst low during PAYLOAD -> all outputs 0 asynchronously. After release, stray bytes 22,33 are discarded in IDLE and a good frame passes.
